// File: rtl/baud_gen_prog.sv
// Programmable UART baud-rate generator.
// Produces an oversample tick (rate*OVS), a bit tick (rate) and a 50%-duty
// baud square wave. The rate comes from a preset table or a custom divisor.
// A new divisor is adopted only at bit boundaries while counting, so the
// bit in progress always completes at the old rate.
//
// Handshake/control semantics: there is no valid/ready handshake here. The
// ticks are single-cycle strobes with no back-pressure. Control priority
// is rst > sync_clr > en=0 > counting.
`timescale 1ns/1ps
module baud_gen_prog #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned OVS    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [2:0]       sel,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             ovs_tick,
    output logic             bit_tick,
    output logic             baud_clk,
    output logic [DIV_W-1:0] div_act
);

    localparam int unsigned PH_W = (OVS > 1) ? $clog2(OVS) : 1;

    // Rounded divisor: clk cycles per oversample tick for a given baud rate.
    function automatic int unsigned preset_div(input int unsigned rate);
        return (CLK_HZ + (rate * OVS) / 2) / (rate * OVS);
    endfunction

    localparam int unsigned D1200  = preset_div(1200);
    localparam int unsigned D2400  = preset_div(2400);
    localparam int unsigned D4800  = preset_div(4800);
    localparam int unsigned D9600  = preset_div(9600);
    localparam int unsigned D19200 = preset_div(19200);
    localparam int unsigned D38400 = preset_div(38400);
    localparam int unsigned D57600 = preset_div(57600);

    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0] PH_PRE_MID = PH_W'(OVS / 2 - 1);

    // The slowest preset is the largest divisor; it must fit the counter.
    if (longint'(D1200) >= (longint'(1) << DIV_W)) begin : g_bad_preset
        $error("baud_gen_prog: preset divisor %0d does not fit in DIV_W=%0d", D1200, DIV_W);
    end

    if (OVS < 2 || OVS > 64 || (OVS & (OVS - 1)) != 0) begin : g_bad_ovs
        $error("baud_gen_prog: OVS=%0d must be a power of 2 in 2..64", OVS);
    end

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             ovs_tick_q, ovs_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             baud_clk_q, baud_clk_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_dec;
    logic             wrap;

    // Decode the requested divisor; custom values below 2 are clamped to 2.
    always_comb begin
        div_dec = div_cfg;
        case (sel)
            3'd0:    div_dec = DIV_W'(D1200);
            3'd1:    div_dec = DIV_W'(D2400);
            3'd2:    div_dec = DIV_W'(D4800);
            3'd3:    div_dec = DIV_W'(D9600);
            3'd4:    div_dec = DIV_W'(D19200);
            3'd5:    div_dec = DIV_W'(D38400);
            3'd6:    div_dec = DIV_W'(D57600);
            default: div_dec = (div_cfg < DIV_W'(2)) ? DIV_W'(2) : div_cfg;
        endcase
    end

    // Next-state: restart, hold, or count with divisor reload at bit boundary.
    always_comb begin
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        ovs_tick_d = 1'b0;
        bit_tick_d = 1'b0;
        baud_clk_d = baud_clk_q;
        div_act_d  = div_act_q;
        // ">=" also recovers if div_act shrank below cnt while disabled.
        wrap       = (cnt_q >= (div_act_q - DIV_W'(1)));
        if (sync_clr) begin
            cnt_d      = '0;
            ph_d       = '0;
            baud_clk_d = 1'b0;
            div_act_d  = div_dec;
        end else if (!en) begin
            div_act_d = div_dec;
        end else if (wrap) begin
            cnt_d      = '0;
            ovs_tick_d = 1'b1;
            ph_d       = ph_q + PH_W'(1);
            if (ph_q == PH_LAST) begin
                bit_tick_d = 1'b1;
                baud_clk_d = 1'b0;
                div_act_d  = div_dec;
            end else if (ph_q == PH_PRE_MID) begin
                baud_clk_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // State and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            ph_q       <= '0;
            ovs_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            baud_clk_q <= 1'b0;
            div_act_q  <= div_dec;
        end else begin
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            ovs_tick_q <= ovs_tick_d;
            bit_tick_q <= bit_tick_d;
            baud_clk_q <= baud_clk_d;
            div_act_q  <= div_act_d;
        end
    end

    assign ovs_tick = ovs_tick_q;
    assign bit_tick = bit_tick_q;
    assign baud_clk = baud_clk_q;
    assign div_act  = div_act_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Bench for baud_gen_prog: the driver pushes the expected cycle of every
// tick and baud_clk edge into queues; a negedge monitor pops and compares
// each event as the DUT produces it.
`timescale 1ns/1ps
module tb_baud_gen_prog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sync_clr = 1'b0;
    logic [2:0]  sel = 3'd3;
    logic [15:0] div_cfg = 16'd0;
    logic        ovs_tick, bit_tick, baud_clk;
    logic [15:0] div_act;

    baud_gen_prog #(.CLK_HZ(50000000), .DIV_W(16), .OVS(16)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
        .sel(sel), .div_cfg(div_cfg),
        .ovs_tick(ovs_tick), .bit_tick(bit_tick),
        .baud_clk(baud_clk), .div_act(div_act)
    );

    // clock / cycle counter
    always #10 clk = ~clk;
    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [31:0] ovs_q[$];
    logic [31:0] bit_q[$];
    logic [31:0] rise_q[$];
    logic [31:0] fall_q[$];
    int errors = 0;
    int checks = 0;
    logic baud_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // monitor
    always @(negedge clk) begin
        if (ovs_tick === 1'b1) begin
            if (ovs_q.size() == 0) unexpected("ovs_tick");
            else check("ovs_tick cycle", cyc, ovs_q.pop_front());
        end
        if (bit_tick === 1'b1) begin
            if (bit_q.size() == 0) unexpected("bit_tick");
            else check("bit_tick cycle", cyc, bit_q.pop_front());
        end
        if (baud_clk === 1'b1 && baud_prev === 1'b0) begin
            if (rise_q.size() == 0) unexpected("baud_rise");
            else check("baud_rise cycle", cyc, rise_q.pop_front());
        end
        if (baud_clk === 1'b0 && baud_prev === 1'b1) begin
            if (fall_q.size() == 0) unexpected("baud_fall");
            else check("baud_fall cycle", cyc, fall_q.pop_front());
        end
        baud_prev = baud_clk;
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_to(input logic [31:0] t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_div);
        check({tag, " ovs_tick"}, 32'(ovs_tick), 32'd0);
        check({tag, " bit_tick"}, 32'(bit_tick), 32'd0);
        check({tag, " baud_clk"}, 32'(baud_clk), 32'd0);
        check({tag, " div_act"}, 32'(div_act), 32'(exp_div));
    endtask

    task automatic do_reset(input logic [2:0] s, input logic [15:0] d, input logic [15:0] exp_div);
        rst = 1'b1;
        en = 1'b0;
        sync_clr = 1'b0;
        sel = s;
        div_cfg = d;
        step(3);
        check_idle("reset", exp_div);
        rst = 1'b0;
    endtask

    logic [31:0] c0, c1, c2;

    initial begin
        step(1);

        // sel=3: D=326, bit period 5216, half period 2608
        do_reset(3'd3, 16'd0, 16'd326);
        en = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 24; k++) ovs_q.push_back(c0 + 326 * k);
        bit_q.push_back(c0 + 5216);
        rise_q.push_back(c0 + 2608);
        fall_q.push_back(c0 + 5216);
        rise_q.push_back(c0 + 7824);
        tick_to(c0 + 100);
        check("9600 div_act", 32'(div_act), 32'd326);
        tick_to(c0 + 7824);
        fall_q.push_back(c0 + 7825);

        // rate change 9600 -> 1200 at cycle 1000, plus a reverted change
        do_reset(3'd3, 16'd0, 16'd326);
        en = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 16; k++) ovs_q.push_back(c0 + 326 * k);
        for (int m = 1; m <= 16; m++) ovs_q.push_back(c0 + 5216 + 2604 * m);
        bit_q.push_back(c0 + 5216);
        bit_q.push_back(c0 + 46880);
        rise_q.push_back(c0 + 2608);
        fall_q.push_back(c0 + 5216);
        rise_q.push_back(c0 + 26048);
        fall_q.push_back(c0 + 46880);
        tick_to(c0 + 500);
        sel = 3'd5;
        tick_to(c0 + 700);
        sel = 3'd3;
        tick_to(c0 + 1000);
        check("revert div_act", 32'(div_act), 32'd326);
        sel = 3'd0;
        tick_to(c0 + 1001);
        check("pending div_act", 32'(div_act), 32'd326);
        tick_to(c0 + 5215);
        check("pre-boundary div_act", 32'(div_act), 32'd326);
        tick_to(c0 + 5216);
        check("boundary div_act", 32'(div_act), 32'd2604);
        tick_to(c0 + 46880);

        // custom divisor clamp: div_cfg=1 -> 2
        do_reset(3'd7, 16'd1, 16'd2);
        en = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 32; k++) ovs_q.push_back(c0 + 2 * k);
        bit_q.push_back(c0 + 32);
        bit_q.push_back(c0 + 64);
        rise_q.push_back(c0 + 16);
        rise_q.push_back(c0 + 48);
        fall_q.push_back(c0 + 32);
        fall_q.push_back(c0 + 64);
        tick_to(c0 + 64);
        en = 1'b0;
        div_cfg = 16'd100;
        step(1);
        check("custom reload while disabled", 32'(div_act), 32'd100);
        step(3);
        check("disabled ovs_tick", 32'(ovs_tick), 32'd0);

        // en low for 500 cycles mid-bit stretches the bit by 500
        do_reset(3'd3, 16'd0, 16'd326);
        en = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 16; k++)
            ovs_q.push_back(c0 + 326 * k + ((326 * k > 1000) ? 500 : 0));
        bit_q.push_back(c0 + 5716);
        rise_q.push_back(c0 + 3108);
        fall_q.push_back(c0 + 5716);
        tick_to(c0 + 1000);
        en = 1'b0;
        tick_to(c0 + 1200);
        check("frozen ovs_tick", 32'(ovs_tick), 32'd0);
        check("frozen div_act", 32'(div_act), 32'd326);
        tick_to(c0 + 1500);
        en = 1'b1;
        tick_to(c0 + 5716);

        // sync_clr at ph=7, then rst mid-bit while baud_clk is high
        do_reset(3'd3, 16'd0, 16'd326);
        en = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 7; k++) ovs_q.push_back(c0 + 326 * k);
        tick_to(c0 + 2400);
        sync_clr = 1'b1;
        step(1);
        check_idle("sync_clr", 16'd326);
        sync_clr = 1'b0;
        c1 = cyc;
        for (int k = 1; k <= 8; k++) ovs_q.push_back(c1 + 326 * k);
        rise_q.push_back(c1 + 2608);
        tick_to(c1 + 2700);
        check("pre-rst baud_clk", 32'(baud_clk), 32'd1);
        fall_q.push_back(c1 + 2701);
        rst = 1'b1;
        step(1);
        check_idle("mid-bit rst", 16'd326);
        rst = 1'b0;
        c2 = cyc;
        ovs_q.push_back(c2 + 326);
        ovs_q.push_back(c2 + 652);
        tick_to(c2 + 652);
        en = 1'b0;
        step(5);

        // every expected event must have been consumed
        check("ovs_q leftover", 32'(ovs_q.size()), 32'd0);
        check("bit_q leftover", 32'(bit_q.size()), 32'd0);
        check("rise_q leftover", 32'(rise_q.size()), 32'd0);
        check("fall_q leftover", 32'(fall_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
